// File: rtl/cp0_exception_ctrl_pkg.sv
// rtl/cp0_exception_ctrl_pkg.sv - shared constants and types for the CP0 exception controller
package cp0_exception_ctrl_pkg;

    // ExcCode values presented to CP0 cause
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    // CP0 status bit positions: global enable plus one mask bit per trap kind
    localparam int ST_IE      = 0;
    localparam int ST_SYSCALL = 1;
    localparam int ST_BREAK   = 2;
    localparam int ST_TEQ     = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_FLUSH  = 2'd2
    } exc_state_t;

endpackage

// File: rtl/cp0_exception_ctrl.sv
// rtl/cp0_exception_ctrl.sv - trap/eret sampler driving CP0 commands, PC redirect and flush
module cp0_exception_ctrl
    import cp0_exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        stall,
    input  logic [31:0] ex_pc,
    input  logic        is_syscall,
    input  logic        is_break,
    input  logic        is_teq,
    input  logic        teq_equal,
    input  logic        is_eret,
    input  logic [31:0] status_in,
    input  logic [31:0] eaddr_in,
    output logic        exception,
    output logic        eret,
    output logic [4:0]  cause,
    output logic [31:0] epc,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic        flush,
    output logic        busy
);

    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    exc_state_t       state, next_state;
    logic [CNT_W-1:0] flush_cnt;
    logic             kind_eret;
    logic             req_gate;
    logic             eret_req;
    logic             trap_taken;
    logic [4:0]       trap_cause;

    // Upper status bits carry nothing this controller cares about
    logic unused_status;
    assign unused_status = ^status_in[31:4];

    // Request decode: eret beats every trap; among enabled traps syscall > break > teq
    always_comb begin
        trap_taken = 1'b0;
        trap_cause = EXC_SYSCALL;
        req_gate   = ex_valid & ~stall;
        eret_req   = req_gate & is_eret;
        if (req_gate && status_in[ST_IE]) begin
            if (is_syscall && status_in[ST_SYSCALL]) begin
                trap_taken = 1'b1;
                trap_cause = EXC_SYSCALL;
            end else if (is_break && status_in[ST_BREAK]) begin
                trap_taken = 1'b1;
                trap_cause = EXC_BREAK;
            end else if (is_teq && teq_equal && status_in[ST_TEQ]) begin
                trap_taken = 1'b1;
                trap_cause = EXC_TEQ;
            end
        end
    end

    // State register, latched request details and flush down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            kind_eret <= 1'b0;
            cause     <= 5'd0;
            epc       <= 32'd0;
            flush_cnt <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (eret_req) begin
                        kind_eret <= 1'b1;
                    end else if (trap_taken) begin
                        kind_eret <= 1'b0;
                        cause     <= trap_cause;
                        epc       <= ex_pc + 32'd4;
                    end
                end
                S_COMMIT: flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                S_FLUSH: begin
                    if (flush_cnt != '0) begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: flush_cnt <= '0;
            endcase
        end
    end

    // Next-state and command outputs; redirect target follows CP0 live during eret commit
    always_comb begin
        next_state    = state;
        exception     = 1'b0;
        eret          = 1'b0;
        pc_redirect   = 1'b0;
        redirect_addr = 32'd0;
        flush         = 1'b0;
        busy          = 1'b0;
        case (state)
            S_IDLE: begin
                if (eret_req || trap_taken) begin
                    next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                exception     = ~kind_eret;
                eret          = kind_eret;
                pc_redirect   = 1'b1;
                redirect_addr = kind_eret ? eaddr_in : EXC_VECTOR;
                flush         = 1'b1;
                busy          = 1'b1;
                next_state    = S_FLUSH;
            end
            S_FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
                if (flush_cnt == '0) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// tb/tb_cp0_exception_ctrl.sv - directed-vector bench for cp0_exception_ctrl
module tb_cp0_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        stall;
    logic [31:0] ex_pc;
    logic        is_syscall;
    logic        is_break;
    logic        is_teq;
    logic        teq_equal;
    logic        is_eret;
    logic [31:0] status_in;
    logic [31:0] eaddr_in;
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic        flush;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    cp0_exception_ctrl #(
        .EXC_VECTOR  (32'h00400004),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .stall        (stall),
        .ex_pc        (ex_pc),
        .is_syscall   (is_syscall),
        .is_break     (is_break),
        .is_teq       (is_teq),
        .teq_equal    (teq_equal),
        .is_eret      (is_eret),
        .status_in    (status_in),
        .eaddr_in     (eaddr_in),
        .exception    (exception),
        .eret         (eret),
        .cause        (cause),
        .epc          (epc),
        .pc_redirect  (pc_redirect),
        .redirect_addr(redirect_addr),
        .flush        (flush),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        ex_valid   = 1'b0;
        is_syscall = 1'b0;
        is_break   = 1'b0;
        is_teq     = 1'b0;
        teq_equal  = 1'b0;
        is_eret    = 1'b0;
    endtask

    // Let the current request be sampled on one rising edge, then withdraw it
    task automatic issue();
        @(posedge clk);
        #1;
        clear_req();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_exception"}, {31'd0, exception}, 32'd0);
        check_eq({tag, "_eret"}, {31'd0, eret}, 32'd0);
        check_eq({tag, "_flush"}, {31'd0, flush}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle_wait"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        ex_pc     = 32'd0;
        status_in = 32'd0;
        eaddr_in  = 32'd0;
        clear_req();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_redirect", {31'd0, pc_redirect}, 32'd0);
        check_eq("reset_cause", {27'd0, cause}, 32'd0);
        check_eq("reset_epc", epc, 32'd0);
        check_eq("reset_raddr", redirect_addr, 32'd0);

        // 1: enabled syscall, commit then two flush cycles
        status_in  = 32'h0000000F;
        ex_pc      = 32'h00400100;
        ex_valid   = 1'b1;
        is_syscall = 1'b1;
        issue();
        @(negedge clk);
        check_eq("t1_exception", {31'd0, exception}, 32'd1);
        check_eq("t1_eret", {31'd0, eret}, 32'd0);
        check_eq("t1_cause", {27'd0, cause}, 32'd8);
        check_eq("t1_epc", epc, 32'h00400104);
        check_eq("t1_redirect", {31'd0, pc_redirect}, 32'd1);
        check_eq("t1_raddr", redirect_addr, 32'h00400004);
        check_eq("t1_flush0", {31'd0, flush}, 32'd1);
        check_eq("t1_busy0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("t1_exc_pulse", {31'd0, exception}, 32'd0);
        check_eq("t1_redirect_pulse", {31'd0, pc_redirect}, 32'd0);
        check_eq("t1_flush1", {31'd0, flush}, 32'd1);
        check_eq("t1_busy1", {31'd0, busy}, 32'd1);
        check_eq("t1_cause_hold", {27'd0, cause}, 32'd8);
        @(negedge clk);
        check_eq("t1_flush2", {31'd0, flush}, 32'd1);
        @(negedge clk);
        check_eq("t1_flush3", {31'd0, flush}, 32'd0);
        check_eq("t1_busy3", {31'd0, busy}, 32'd0);
        check_eq("t1_epc_hold", epc, 32'h00400104);

        // 2: masked syscall and masked break
        status_in  = 32'h0000000D;
        ex_pc      = 32'h00400800;
        ex_valid   = 1'b1;
        is_syscall = 1'b1;
        issue();
        @(negedge clk);
        check_idle_outputs("t2_sys_masked");
        check_eq("t2_epc_unlatched", epc, 32'h00400104);
        status_in = 32'h0000000B;
        ex_valid  = 1'b1;
        is_break  = 1'b1;
        issue();
        @(negedge clk);
        check_idle_outputs("t2_brk_masked");

        // 3: teq only traps when operands are equal
        status_in = 32'h0000000F;
        ex_pc     = 32'h00400200;
        ex_valid  = 1'b1;
        is_teq    = 1'b1;
        teq_equal = 1'b0;
        issue();
        @(negedge clk);
        check_idle_outputs("t3_teq_ne");
        ex_valid  = 1'b1;
        is_teq    = 1'b1;
        teq_equal = 1'b1;
        issue();
        @(negedge clk);
        check_eq("t3_exception", {31'd0, exception}, 32'd1);
        check_eq("t3_cause", {27'd0, cause}, 32'd13);
        check_eq("t3_epc", epc, 32'h00400204);
        wait_idle("t3");

        // 4: eret ignores status, redirects to CP0's EPC; eret wins over syscall
        status_in = 32'h00000000;
        eaddr_in  = 32'h00400104;
        ex_valid  = 1'b1;
        is_eret   = 1'b1;
        issue();
        @(negedge clk);
        check_eq("t4_eret", {31'd0, eret}, 32'd1);
        check_eq("t4_exception", {31'd0, exception}, 32'd0);
        check_eq("t4_raddr", redirect_addr, 32'h00400104);
        check_eq("t4_redirect", {31'd0, pc_redirect}, 32'd1);
        @(negedge clk);
        check_eq("t4_eret_pulse", {31'd0, eret}, 32'd0);
        wait_idle("t4a");
        status_in  = 32'h0000000F;
        eaddr_in   = 32'h00400abc;
        ex_valid   = 1'b1;
        is_eret    = 1'b1;
        is_syscall = 1'b1;
        issue();
        @(negedge clk);
        check_eq("t4_both_eret", {31'd0, eret}, 32'd1);
        check_eq("t4_both_exc", {31'd0, exception}, 32'd0);
        check_eq("t4_both_raddr", redirect_addr, 32'h00400abc);
        wait_idle("t4b");

        // 5a: requests arriving while busy are dropped
        ex_pc      = 32'h00400300;
        ex_valid   = 1'b1;
        is_syscall = 1'b1;
        issue();
        ex_pc      = 32'h00400500;
        ex_valid   = 1'b1;
        is_syscall = 1'b1;
        @(negedge clk);
        check_eq("t5_first_epc", epc, 32'h00400304);
        repeat (3) @(posedge clk);
        #1;
        clear_req();
        @(negedge clk);
        check_idle_outputs("t5_busy_drop");
        check_eq("t5_busy_epc", epc, 32'h00400304);

        // 5b: stall holds off acceptance; commit follows release by one cycle
        stall      = 1'b1;
        ex_pc      = 32'h00400600;
        ex_valid   = 1'b1;
        is_syscall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t5_stall_busy%0d", i), {31'd0, busy}, 32'd0);
        end
        #1;
        stall = 1'b0;
        issue();
        @(negedge clk);
        check_eq("t5_release_exc", {31'd0, exception}, 32'd1);
        check_eq("t5_release_epc", epc, 32'h00400604);
        wait_idle("t5");

        // 6: reset in the middle of the flush sequence
        ex_pc      = 32'h00400400;
        ex_valid   = 1'b1;
        is_syscall = 1'b1;
        issue();
        @(negedge clk);
        check_eq("t6_commit", {31'd0, exception}, 32'd1);
        @(negedge clk);
        check_eq("t6_in_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("t6_after_rst");
        check_eq("t6_epc_rst", epc, 32'd0);
        ex_pc      = 32'h00400700;
        ex_valid   = 1'b1;
        is_syscall = 1'b1;
        issue();
        @(negedge clk);
        check_eq("t6_new_exc", {31'd0, exception}, 32'd1);
        check_eq("t6_new_epc", epc, 32'h00400704);
        wait_idle("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
